// File: rtl/spi_scene_receiver.sv
// Receives fixed-length SPI mode-0 frames from the MCU and hands each complete word to the raytracer.
// Latency: recv_dv pulses SYNC_STAGES+2 clocks after the clock edge that first samples spi_cs_n high.
// Backpressure: none; the word is delivered regardless, and spi_irq tells the MCU when to send.
module spi_scene_receiver #(
    parameter int WORD_BITS   = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 CLK100MHZ,
    input  logic                 ck_rst_,
    input  logic                 spi_sclk,
    input  logic                 spi_mosi,
    input  logic                 spi_cs_n,
    input  logic                 recv_interrupt,
    output logic                 recv_dv,
    output logic [WORD_BITS-1:0] recv_64bit,
    output logic                 spi_irq,
    output logic                 frame_err,
    output logic [7:0]           frame_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        DONE    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    localparam logic [6:0] WORD_CNT = 7'(WORD_BITS);
    // A cs_n fall seen this soon after reset was already low at the pin: mid-frame restart.
    localparam logic [2:0] INIT_WIN = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;

    logic sclk_prev_q;
    logic cs_prev_q;
    logic sclk_rise_q;
    logic cs_rise_q;
    logic cs_fall_q;
    logic mosi_q;
    logic [2:0] init_cnt_q;

    state_t                 state_q, state_d;
    logic [6:0]             bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0]   shift_q, shift_d;
    logic                   dv_q, dv_d;
    logic [WORD_BITS-1:0]   word_q, word_d;
    logic                   err_q, err_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   irq_q;

    logic sclk_s;
    logic mosi_s;
    logic cs_s;
    logic in_init_win;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s        = cs_sync_q[SYNC_STAGES-1];
    assign in_init_win = (init_cnt_q <= INIT_WIN);

    always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
        if (!ck_rst_) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        end
    end

    // Edge strobes are registered; mosi is delayed alongside so it lines up with sclk_rise_q.
    always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
        if (!ck_rst_) begin
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            sclk_rise_q <= 1'b0;
            cs_rise_q   <= 1'b0;
            cs_fall_q   <= 1'b0;
            mosi_q      <= 1'b0;
            init_cnt_q  <= 3'd0;
        end else begin
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            sclk_rise_q <= sclk_s & ~sclk_prev_q;
            cs_rise_q   <= cs_s & ~cs_prev_q;
            cs_fall_q   <= ~cs_s & cs_prev_q;
            mosi_q      <= mosi_s;
            if (init_cnt_q != 3'd7) begin
                init_cnt_q <= init_cnt_q + 3'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        dv_d      = 1'b0;
        word_d    = word_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (cs_fall_q) begin
                    if (in_init_win) begin
                        state_d = DISCARD;
                    end else begin
                        state_d   = SHIFT;
                        bit_cnt_d = 7'd0;
                        shift_d   = '0;
                    end
                end
            end
            SHIFT: begin
                // cs_n rise wins over a coincident sclk rise.
                if (cs_rise_q) begin
                    if (bit_cnt_q == WORD_CNT) begin
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end else if (sclk_rise_q) begin
                    if (bit_cnt_q == WORD_CNT) begin
                        state_d = DISCARD;
                        err_d   = 1'b1;
                    end else begin
                        shift_d   = {shift_q[WORD_BITS-2:0], mosi_q};
                        bit_cnt_d = bit_cnt_q + 7'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                dv_d    = 1'b1;
                word_d  = shift_q;
                cnt_d   = cnt_q + 8'd1;
                err_d   = 1'b0;
            end
            DISCARD: begin
                if (cs_rise_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
        if (!ck_rst_) begin
            state_q   <= IDLE;
            bit_cnt_q <= 7'd0;
            shift_q   <= '0;
            dv_q      <= 1'b0;
            word_q    <= '0;
            err_q     <= 1'b0;
            cnt_q     <= 8'd0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            dv_q      <= dv_d;
            word_q    <= word_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            irq_q     <= recv_interrupt;
        end
    end

    assign recv_dv    = dv_q;
    assign recv_64bit = word_q;
    assign spi_irq    = irq_q;
    assign frame_err  = err_q;
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_spi_scene_receiver.sv
// Randomized SPI frame bench with a frame-level reference model and a strobe scoreboard.
module tb_spi_scene_receiver;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  sclk_p, mosi_p, cs_p;
    logic        ri;

    logic        dv_a, irq_a, err_a;
    logic [63:0] word_a;
    logic [7:0]  cnt_a;
    logic        dv_b, irq_b, err_b;
    logic [7:0]  word_b;
    logic [7:0]  cnt_b;

    always #5 clk = ~clk;

    spi_scene_receiver #(.WORD_BITS(64), .SYNC_STAGES(S)) u_dut (
        .CLK100MHZ(clk), .ck_rst_(rst_n),
        .spi_sclk(sclk_p[0]), .spi_mosi(mosi_p[0]), .spi_cs_n(cs_p[0]),
        .recv_interrupt(ri), .recv_dv(dv_a), .recv_64bit(word_a),
        .spi_irq(irq_a), .frame_err(err_a), .frame_cnt(cnt_a)
    );

    // Narrow-word instance so that 256 frames fit in a short run.
    spi_scene_receiver #(.WORD_BITS(8), .SYNC_STAGES(S)) u_wrap (
        .CLK100MHZ(clk), .ck_rst_(rst_n),
        .spi_sclk(sclk_p[1]), .spi_mosi(mosi_p[1]), .spi_cs_n(cs_p[1]),
        .recv_interrupt(ri), .recv_dv(dv_b), .recv_64bit(word_b),
        .spi_irq(irq_b), .frame_err(err_b), .frame_cnt(cnt_b)
    );

    typedef struct {
        logic [63:0] word;
        logic [7:0]  cnt;
        int          rise_cyc;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          strobes_b = 0;
    logic [63:0] mdl_word = '0;
    int          mdl_cnt = 0;
    bit          mdl_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && dv_a === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_strobe: recv_dv=1 with no frame pending, expected 0");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("strobe_word", word_a, e.word);
                check("strobe_frame_cnt", cnt_a, e.cnt);
                check("strobe_frame_err", err_a, 64'd0);
                check("strobe_latency", 64'(cyc - e.rise_cyc - 1), 64'(S + 2));
            end
        end
        if (rst_n === 1'b1 && dv_b === 1'b1) strobes_b++;
    end

    // One SPI mode-0 frame of nbits edges, MSB first, on interface d.
    // simul raises an extra sclk edge together with cs_n; rst_at pulses reset before that bit.
    task automatic spi_frame(input int d, input int nbits, input logic [127:0] bits,
                             input bit simul, input int rst_at, input int half);
        int   wb;
        bit   did_rst;
        bit   accepted;
        exp_t e;
        wb      = (d == 0) ? 64 : 8;
        did_rst = 1'b0;
        cs_p[d] = 1'b0;
        wait_cyc(half);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                ri    = 1'b1;
                wait_cyc(3);
                check("rst_recv_dv", dv_a, 64'd0);
                check("rst_recv_64bit", word_a, 64'd0);
                check("rst_frame_cnt", cnt_a, 64'd0);
                check("rst_frame_err", err_a, 64'd0);
                check("rst_spi_irq", irq_a, 64'd0);
                rst_n    = 1'b1;
                ri       = 1'b0;
                mdl_word = '0;
                mdl_cnt  = 0;
                did_rst  = 1'b1;
            end
            mosi_p[d] = bits[nbits-1-i];
            wait_cyc(half);
            sclk_p[d] = 1'b1;
            wait_cyc(half);
            sclk_p[d] = 1'b0;
        end
        wait_cyc(half);
        accepted = (nbits == wb) && !did_rst;
        if (d == 0 && nbits > wb && !did_rst) check("overrun_err_before_cs_rise", err_a, 64'd1);
        if (d == 0 && accepted) begin
            e.word     = bits[63:0];
            e.cnt      = 8'(mdl_cnt + 1);
            e.rise_cyc = cyc;
            sbq.push_back(e);
        end
        if (simul) begin
            mosi_p[d] = 1'($urandom);
            sclk_p[d] = 1'b1;
        end
        cs_p[d] = 1'b1;
        wait_cyc(half);
        sclk_p[d] = 1'b0;
        wait_cyc(8);
        if (d == 0) begin
            if (accepted) begin
                mdl_word = bits[63:0];
                mdl_cnt  = (mdl_cnt + 1) % 256;
                mdl_err  = 1'b0;
            end else begin
                mdl_err = !did_rst;
            end
            check("strobe_delivered", 64'(sbq.size()), 64'd0);
            check("frame_err", err_a, 64'(mdl_err));
            check("frame_cnt", cnt_a, 64'(mdl_cnt));
            check("recv_64bit_held", word_a, mdl_word);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lens[7];
        logic [127:0] r;
        logic        ri_prev;
        logic [7:0]  bdat;
        lens = '{62, 63, 64, 64, 64, 65, 66};
        rst_n  = 1'b0;
        sclk_p = 2'b00;
        mosi_p = 2'b00;
        cs_p   = 2'b11;
        ri     = 1'b1;
        wait_cyc(3);
        check("reset_recv_dv", dv_a, 64'd0);
        check("reset_recv_64bit", word_a, 64'd0);
        check("reset_frame_err", err_a, 64'd0);
        check("reset_frame_cnt", cnt_a, 64'd0);
        check("reset_spi_irq", irq_a, 64'd0);
        rst_n = 1'b1;
        ri    = 1'b0;
        wait_cyc(10);

        // Valid frame with recv_interrupt held low.
        spi_frame(0, 64, 128'h000A_0028_0000_0A00, 1'b0, -1, 5);
        // Underrun then all-ones.
        spi_frame(0, 63, 128'h1234_5678_9ABC_DEF0, 1'b0, -1, 5);
        spi_frame(0, 64, 128'hFFFF_FFFF_FFFF_FFFF, 1'b0, -1, 5);
        // Overrun.
        spi_frame(0, 65, {$urandom, $urandom, $urandom, $urandom}, 1'b0, -1, 5);
        // Coincident sclk/cs_n rise after bit 64.
        spi_frame(0, 64, {$urandom, $urandom, $urandom, $urandom}, 1'b1, -1, 5);

        for (int k = 0; k < 8; k++) begin
            int n;
            n = lens[$urandom_range(0, 6)];
            r = {$urandom, $urandom, $urandom, $urandom};
            spi_frame(0, n, r, (n == 64) ? 1'($urandom) : 1'b0, -1, $urandom_range(4, 6));
        end

        // Reset mid-frame, then a normal frame.
        spi_frame(0, 64, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 20, 5);
        spi_frame(0, 64, {$urandom, $urandom, $urandom, $urandom}, 1'b0, -1, 5);

        ri_prev = ri;
        for (int k = 0; k < 30; k++) begin
            wait_cyc(1);
            check("spi_irq_follows", irq_a, 64'(ri_prev));
            check("spi_irq_follows_b", irq_b, 64'(ri_prev));
            ri = 1'($urandom);
            #1;
            check("spi_irq_registered", irq_a, 64'(ri_prev));
            ri_prev = ri;
        end

        for (int k = 0; k < 256; k++) begin
            bdat = 8'($urandom);
            spi_frame(1, 8, {120'd0, bdat}, 1'b0, -1, 4);
            check("wrap_frame_cnt", cnt_b, 64'((k + 1) % 256));
            check("wrap_word", word_b, 64'(bdat));
        end
        check("wrap_strobe_count", 64'(strobes_b), 64'd256);
        check("wrap_cnt_zero", cnt_b, 64'd0);
        check("final_sb_empty", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
